// File: rtl/serial_subtractor_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_ctrl_if
//   Bundles the operand handshake (in_valid/in_ready, a, b, bin) and the result
//   handshake (out_valid/out_ready, diff, borrow) plus the busy status of the
//   serial subtractor into one interface.
//   master : operand producer / result consumer side
//   slave  : serial_subtractor_ctrl side
// ----------------------------------------------------------------------------
interface serial_subtractor_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             busy;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, borrow, busy
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, borrow, busy
   );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// ----------------------------------------------------------------------------
// serial_subtractor_ctrl
//   Computes (a - b - bin) mod 2^WIDTH and the final borrow using a single
//   1-bit full-subtractor cell, one bit per clock, LSB first.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of serial_subtractor_ctrl_if:
//            in_valid/in_ready + a, b, bin   operand handshake
//            out_valid/out_ready + diff, borrow  result handshake
//            busy  high while bits are being processed
//   Timing: out_valid rises WIDTH clocks after the accepting edge; with
//   out_ready held high one operation completes every WIDTH+2 clocks.
// ----------------------------------------------------------------------------
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   serial_subtractor_ctrl_if.slave  bus
);

   localparam int               CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic             breg_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;

   logic             dbit_s;
   logic             bout_s;
   logic [WIDTH-1:0] res_next_s;

   // Full-subtractor cell: returns {bout, diff}.
   function automatic logic [1:0] full_sub(input logic fa, input logic fb, input logic fbin);
      logic d;
      logic bo;
      d  = fa ^ fb ^ fbin;
      bo = (~fa & fb) | (~fa & fbin) | (fb & fbin);
      return {bo, d};
   endfunction

   // Shared cell evaluation and result shift-in of the new diff bit at the MSB.
   always_comb begin
      {bout_s, dbit_s}      = full_sub(a_sh_r[0], b_sh_r[0], breg_r);
      // Shift then overwrite the MSB; written this way so WIDTH=1 needs no slice.
      res_next_s            = res_r >> 1;
      res_next_s[WIDTH-1]   = dbit_s;
   end

   // Control FSM with datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         a_sh_r      <= {WIDTH{1'b0}};
         b_sh_r      <= {WIDTH{1'b0}};
         breg_r      <= 1'b0;
         cnt_r       <= {CW{1'b0}};
         res_r       <= {WIDTH{1'b0}};
         diff_r      <= {WIDTH{1'b0}};
         borrow_r    <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  a_sh_r     <= bus.a;
                  b_sh_r     <= bus.b;
                  breg_r     <= bus.bin;
                  cnt_r      <= {CW{1'b0}};
                  res_r      <= {WIDTH{1'b0}};
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= RUN;
               end
            end
            RUN: begin
               a_sh_r <= a_sh_r >> 1;
               b_sh_r <= b_sh_r >> 1;
               breg_r <= bout_s;
               res_r  <= res_next_s;
               cnt_r  <= cnt_r + CW'(1);
               if (cnt_r == LAST) begin
                  // Final bit: publish the completed result on this same edge.
                  diff_r      <= res_next_s;
                  borrow_r    <= bout_s;
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               if (out_valid_r && bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.diff      = diff_r;
   assign bus.borrow    = borrow_r;

endmodule
